marquee_scroll_ctrl: RTL and testbench

- Sequencer that owns the rotate offset of the LED/7-seg marquee datapath.
- Receives start/stop pulses, a mode select and a step size.
- Each clk_out tick it produces a modulo-WIDTH rotate offset and a direction flag, plus status (running, wrap pulse, state).
- Supports continuous left/right rotation and a bounce mode with end-dwell.
- Sits between the debounced button/switch logic and the combinational rotator; replaces ad-hoc offset counting with exact modular wrap.

---
 rtl/marquee_scroll_ctrl.sv | 173 +++++++++++++++++
 tb/tb_marquee_scroll_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/marquee_scroll_ctrl.sv
// Marquee rotate-offset sequencer: rotate left/right or bounce with end dwell.
// Latency: one clk_out tick from start/stop/pause/advance to registered outputs.
// Backpressure: none; pause holds offset, state and dwell counter in place.
module marquee_scroll_ctrl #(
    parameter int WIDTH       = 32,
    parameter int WINDOW      = 4,
    parameter int DWELL_TICKS = 4
) (
    input  logic       clk_out,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic [4:0] step,
    output logic [6:0] shift_offset,
    output logic       shift_dir,
    output logic       running,
    output logic       wrap_pulse,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROT_L  = 3'd1,
        ROT_R  = 3'd2,
        B_UP   = 3'd3,
        B_TOP  = 3'd4,
        B_DOWN = 3'd5,
        B_BOT  = 3'd6
    } state_t;

    localparam logic [7:0] WIDTH_L  = 8'(WIDTH);
    localparam logic [7:0] LIMIT_L  = 8'(WIDTH - WINDOW);
    localparam logic [6:0] LIMIT_O  = 7'(WIDTH - WINDOW);
    localparam logic [5:0] STEP_MAX = 6'(WIDTH - 1);
    localparam logic [3:0] DWELL_L  = 4'(DWELL_TICKS);

    state_t     state_q, state_d;
    logic [6:0] offset_q, offset_d;
    logic       dir_q, dir_d;
    logic       wrap_q, wrap_d;
    logic [5:0] step_q, step_d;
    logic [3:0] dwell_q, dwell_d;
    logic [5:0] step_san;
    logic [7:0] off_w, step_w, sum_up;

    // Clamp the requested step so a single tick never moves a full word or more.
    always_comb begin
        step_san = {1'b0, step};
        if (step == 5'd0) begin
            step_san = 6'd1;
        end else if ({1'b0, step} > STEP_MAX) begin
            step_san = STEP_MAX;
        end
    end

    assign off_w  = {1'b0, offset_q};
    assign step_w = {2'b00, step_q};
    assign sum_up = off_w + step_w;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        step_d   = step_q;
        dwell_d  = dwell_q;

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            step_d = step_san;
            case (mode)
                2'b01: begin
                    state_d = ROT_R;
                    dir_d   = 1'b1;
                end
                2'b10: begin
                    state_d = B_UP;
                    dir_d   = 1'b0;
                end
                default: begin
                    state_d = ROT_L;
                    dir_d   = 1'b0;
                end
            endcase
        end else if (!pause) begin
            case (state_q)
                IDLE: ;
                ROT_L: begin
                    if (sum_up >= WIDTH_L) begin
                        offset_d = 7'(sum_up - WIDTH_L);
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = 7'(sum_up);
                    end
                end
                ROT_R: begin
                    if (off_w < step_w) begin
                        offset_d = 7'(off_w + WIDTH_L - step_w);
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = 7'(off_w - step_w);
                    end
                end
                B_UP: begin
                    // Also clamps an offset inherited from a rotate run above LIMIT.
                    if (sum_up >= LIMIT_L) begin
                        offset_d = LIMIT_O;
                        wrap_d   = 1'b1;
                        dwell_d  = DWELL_L;
                        state_d  = B_TOP;
                    end else begin
                        offset_d = 7'(sum_up);
                    end
                end
                B_TOP: begin
                    dwell_d = dwell_q - 4'd1;
                    if (dwell_q <= 4'd1) begin
                        dwell_d = 4'd0;
                        state_d = B_DOWN;
                        dir_d   = 1'b1;
                    end
                end
                B_DOWN: begin
                    if (off_w <= step_w) begin
                        offset_d = 7'd0;
                        wrap_d   = 1'b1;
                        dwell_d  = DWELL_L;
                        state_d  = B_BOT;
                    end else begin
                        offset_d = 7'(off_w - step_w);
                    end
                end
                B_BOT: begin
                    dwell_d = dwell_q - 4'd1;
                    if (dwell_q <= 4'd1) begin
                        dwell_d = 4'd0;
                        state_d = B_UP;
                        dir_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            offset_q <= 7'd0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            step_q   <= 6'd1;
            dwell_q  <= 4'd0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            step_q   <= step_d;
            dwell_q  <= dwell_d;
        end
    end

    assign shift_offset = offset_q;
    assign shift_dir    = dir_q;
    assign wrap_pulse   = wrap_q;
    assign state        = state_q;
    assign running      = (state_q != IDLE);

endmodule

// File: tb/tb_marquee_scroll_ctrl.sv
// Bench for marquee_scroll_ctrl: directed vector tables plus random stimulus vs a reference model.
module tb_marquee_scroll_ctrl;

    logic       clk_out = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       pause   = 1'b0;
    logic [1:0] mode    = 2'd0;
    logic [4:0] step    = 5'd0;

    logic [6:0] a_off, b_off;
    logic       a_dir, b_dir, a_run, b_run, a_wrap, b_wrap;
    logic [2:0] a_st, b_st;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_out = ~clk_out;

    marquee_scroll_ctrl #(.WIDTH(32), .WINDOW(4), .DWELL_TICKS(4)) dut_a (
        .clk_out(clk_out), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .step(step), .shift_offset(a_off), .shift_dir(a_dir),
        .running(a_run), .wrap_pulse(a_wrap), .state(a_st));

    marquee_scroll_ctrl #(.WIDTH(16), .WINDOW(4), .DWELL_TICKS(2)) dut_b (
        .clk_out(clk_out), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .step(step), .shift_offset(b_off), .shift_dir(b_dir),
        .running(b_run), .wrap_pulse(b_wrap), .state(b_st));

    // Reference model: position, direction, run kind and remaining dwell per instance.
    int MW[2] = '{32, 16};
    int ML[2] = '{28, 12};
    int MD[2] = '{4, 2};
    int m_off[2], m_stp[2], m_dwl[2];
    bit m_run[2], m_bnc[2], m_dir[2], m_wrap[2];

    function automatic int m_state(input int i);
        if (!m_run[i]) return 0;
        if (!m_bnc[i]) return m_dir[i] ? 2 : 1;
        if (m_dwl[i] > 0) return m_dir[i] ? 6 : 4;
        return m_dir[i] ? 5 : 3;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_off[i] = 0; m_stp[i] = 1; m_dwl[i] = 0;
            m_run[i] = 0; m_bnc[i] = 0; m_dir[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic m_step(input int i);
        int s;
        m_wrap[i] = 0;
        s = int'(step);
        if (stop) begin
            m_run[i] = 0;
        end else if (start) begin
            m_stp[i] = (s == 0) ? 1 : ((s > MW[i] - 1) ? MW[i] - 1 : s);
            m_run[i] = 1;
            m_bnc[i] = (mode == 2'd2);
            m_dir[i] = (mode == 2'd1);
            m_dwl[i] = 0;
        end else if (pause || !m_run[i]) begin
            // frozen
        end else if (!m_bnc[i]) begin
            if (!m_dir[i]) m_wrap[i] = (m_off[i] + m_stp[i] >= MW[i]);
            else           m_wrap[i] = (m_off[i] < m_stp[i]);
            m_off[i] = m_dir[i] ? (m_off[i] - m_stp[i] + MW[i]) % MW[i]
                                : (m_off[i] + m_stp[i]) % MW[i];
        end else if (m_dwl[i] > 0) begin
            m_dwl[i]--;
            if (m_dwl[i] == 0) m_dir[i] = !m_dir[i];
        end else if (!m_dir[i]) begin
            if (m_off[i] + m_stp[i] >= ML[i]) begin
                m_off[i] = ML[i]; m_wrap[i] = 1; m_dwl[i] = MD[i];
            end else m_off[i] += m_stp[i];
        end else begin
            if (m_off[i] <= m_stp[i]) begin
                m_off[i] = 0; m_wrap[i] = 1; m_dwl[i] = MD[i];
            end else m_off[i] -= m_stp[i];
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input int off, input int wr, input int dir, input int st);
        chk({nm, " off"}, int'(a_off), off);
        chk({nm, " wrap"}, int'(a_wrap), wr);
        chk({nm, " dir"}, int'(a_dir), dir);
        chk({nm, " state"}, int'(a_st), st);
        chk({nm, " running"}, int'(a_run), (st != 0) ? 1 : 0);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, " a off"}, int'(a_off), m_off[0]);
        chk({nm, " a wrap"}, int'(a_wrap), int'(m_wrap[0]));
        chk({nm, " a dir"}, int'(a_dir), int'(m_dir[0]));
        chk({nm, " a state"}, int'(a_st), m_state(0));
        chk({nm, " b off"}, int'(b_off), m_off[1]);
        chk({nm, " b wrap"}, int'(b_wrap), int'(m_wrap[1]));
        chk({nm, " b dir"}, int'(b_dir), int'(m_dir[1]));
        chk({nm, " b state"}, int'(b_st), m_state(1));
        chk({nm, " b running"}, int'(b_run), int'(m_run[1]));
    endtask

    // Called at a negedge; asserts reset between clock edges and checks outputs at once.
    task automatic do_reset(input string nm);
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk_a({nm, " rst_a"}, 0, 0, 0, 0);
        chk({nm, " rst_b off"}, int'(b_off), 0);
        chk({nm, " rst_b running"}, int'(b_run), 0);
        #1 reset = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_out);
        m_step(0);
        m_step(1);
        @(negedge clk_out);
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
    endtask

    typedef struct {
        bit       start;
        bit       stop;
        bit       pause;
        bit [1:0] mode;
        bit [4:0] step;
        int       off;
        int       wrap;
        int       dir;
        int       st;
    } vec_t;

    function automatic vec_t mk(input bit sa, input bit so, input bit pa, input bit [1:0] md,
                                input bit [4:0] sp, input int off, input int wr, input int dir,
                                input int st);
        vec_t v;
        v.start = sa; v.stop = so; v.pause = pa; v.mode = md; v.step = sp;
        v.off = off; v.wrap = wr; v.dir = dir; v.st = st;
        return v;
    endfunction

    task automatic run_tbl(input vec_t t[$], input string nm);
        foreach (t[k]) begin
            start = t[k].start; stop = t[k].stop; pause = t[k].pause;
            mode = t[k].mode; step = t[k].step;
            tick();
            chk_a($sformatf("%s[%0d]", nm, k), t[k].off, t[k].wrap, t[k].dir, t[k].st);
        end
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    int   exp_a[3] = '{31, 30, 29};
    int   exp_b[3] = '{15, 14, 13};
    int   exp_w[3] = '{0, 1, 1};

    initial begin
        // Rotate left, rotate right, reserved mode, step sanitising, pause, start+stop, live-input isolation.
        tbl_a.push_back(mk(1, 0, 0, 2'd0, 5'd4, 0, 0, 0, 1));
        for (int k = 1; k <= 7; k++) tbl_a.push_back(mk(0, 0, 0, 2'd1, 5'd9, 4 * k, 0, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 2'd0, 5'd4, 0, 1, 0, 1));
        tbl_a.push_back(mk(0, 1, 0, 2'd0, 5'd4, 0, 0, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 2'd1, 5'd3, 0, 0, 1, 2));
        tbl_a.push_back(mk(0, 0, 0, 2'd0, 5'd7, 29, 1, 1, 2));
        tbl_a.push_back(mk(0, 0, 0, 2'd0, 5'd7, 26, 0, 1, 2));
        tbl_a.push_back(mk(0, 0, 0, 2'd0, 5'd7, 23, 0, 1, 2));
        tbl_a.push_back(mk(1, 0, 0, 2'd3, 5'd21, 23, 0, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 2'd0, 5'd1, 12, 1, 0, 1));
        for (int k = 0; k < 3; k++) tbl_a.push_back(mk(0, 0, 1, 2'd0, 5'd1, 12, 0, 0, 1));
        tbl_a.push_back(mk(1, 1, 0, 2'd2, 5'd6, 12, 0, 0, 0));
        tbl_a.push_back(mk(1, 0, 0, 2'd0, 5'd0, 12, 0, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 2'd2, 5'd9, 13, 0, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 2'd2, 5'd9, 14, 0, 0, 1));
        tbl_a.push_back(mk(0, 0, 1, 2'd1, 5'd9, 14, 0, 0, 1));
        tbl_a.push_back(mk(0, 0, 0, 2'd1, 5'd9, 15, 0, 0, 1));
        tbl_a.push_back(mk(0, 1, 0, 2'd1, 5'd9, 15, 0, 0, 0));

        // Bounce through both ends, then pause while dwelling at the top.
        tbl_b.push_back(mk(1, 0, 0, 2'd2, 5'd5, 0, 0, 0, 3));
        for (int k = 1; k <= 5; k++) tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd9, 5 * k, 0, 0, 3));
        tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd9, 28, 1, 0, 4));
        for (int k = 0; k < 3; k++) tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd9, 28, 0, 0, 4));
        tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd9, 28, 0, 1, 5));
        for (int k = 1; k <= 5; k++) tbl_b.push_back(mk(0, 0, 0, 2'd1, 5'd2, 28 - 5 * k, 0, 1, 5));
        tbl_b.push_back(mk(0, 0, 0, 2'd1, 5'd2, 0, 1, 1, 6));
        for (int k = 0; k < 3; k++) tbl_b.push_back(mk(0, 0, 0, 2'd1, 5'd2, 0, 0, 1, 6));
        tbl_b.push_back(mk(0, 0, 0, 2'd1, 5'd2, 0, 0, 0, 3));
        for (int k = 1; k <= 5; k++) tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd0, 5 * k, 0, 0, 3));
        tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd0, 28, 1, 0, 4));
        tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd0, 28, 0, 0, 4));
        for (int k = 0; k < 3; k++) tbl_b.push_back(mk(0, 0, 1, 2'd0, 5'd0, 28, 0, 0, 4));
        tbl_b.push_back(mk(0, 0, 0, 2'd0, 5'd0, 28, 0, 0, 4));

        do_reset("init");
        run_tbl(tbl_a, "rot");

        @(negedge clk_out);
        do_reset("pre_bounce");
        run_tbl(tbl_b, "bnc");
        // Now in B_TOP with two dwell ticks left: reset must take effect without a clock edge.
        do_reset("mid_dwell");
        start = 1'b1; mode = 2'd0; step = 5'd4;
        tick();
        chk_a("resume0", 0, 0, 0, 1);
        tick();
        chk_a("resume1", 4, 0, 0, 1);

        // Oversized step on both widths.
        do_reset("pre_step31");
        start = 1'b1; mode = 2'd0; step = 5'd31;
        tick();
        chk("step31 b start off", int'(b_off), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("step31 a off[%0d]", k), int'(a_off), exp_a[k]);
            chk($sformatf("step31 a wrap[%0d]", k), int'(a_wrap), exp_w[k]);
            chk($sformatf("step31 b off[%0d]", k), int'(b_off), exp_b[k]);
            chk($sformatf("step31 b wrap[%0d]", k), int'(b_wrap), exp_w[k]);
        end

        // Random stimulus against the reference model on both instances.
        do_reset("pre_rand");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset($sformatf("rand_rst%0d", i));
            start = ($urandom_range(0, 29) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            pause = ($urandom_range(0, 7) == 0);
            mode  = 2'($urandom_range(0, 3));
            step  = 5'($urandom_range(0, 31));
            tick();
            chk_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
